idexwb_fwd_pipe: RTL and testbench
==================================

// Module: idexwb_fwd_pipe
// PURPOSE
//  Parametrised decode/execute/writeback pipeline. Successor of the fixed 32-bit idexwb stage.
//  - Takes predecoded fields (opcode, Rs1, Rs2, Rd, imm) from the fetch/predecode front end.
//  - Reads the internal register file, executes, writes back.
//  - Adds an extended opcode set, a multi-cycle multiplier, RAW hazard handling and an
//    upstream stall output.
// PARAMETERS
//  WIDTH    32  datapath / register width in bits (>=12)
//  NREGS    32  register-file entries; RF[0] reads 0 and ignores writes
//  AW       5   register-address width; NREGS <= 2**AW
//  MUL_LAT  2   EX cycles taken by OPMUL (>=1)
// PORTS
//  clk     in   1      rising-edge clock
//  rst     in   1      asynchronous, active-low reset
//  start   in   1      1 = issue the instruction on the inputs this cycle
//  opcode  in   3      000 NOP, 001 ADD, 010 MUL, 011 ADDI, 100 SUB, 101 AND, 110 OR, 111 XOR
//  Rs1     in   AW     source register 1
//  Rs2     in   AW     source register 2 (ignored by ADDI)
//  Rd      in   AW     destination register
//  imm     in   12     ADDI immediate, two's complement
//  stall   out  1      1 = instruction on the inputs is NOT accepted; front end must hold it
//  res     out  WIDTH  signed result of the instruction in WB
//  Rdout   out  AW     destination of the instruction in WB
//  wb_valid out 1      1 = res/Rdout carry a real instruction this cycle
// BEHAVIOUR
//  - Reset (rst=0, async): clear all pipeline registers, MUL counter and RF[0..NREGS-1].
//    Outputs: res=0, Rdout=0, wb_valid=0, stall=0. Any in-flight instruction is discarded.
//  - Accept: at a rising edge with start=1 && stall=0 && opcode!=NOP, the instruction enters
//    ID/EX with its operands resolved. Otherwise a bubble enters.
//  - NOP never writes and never raises wb_valid.
//  - Latency, single-cycle ops:
//    - accepted at edge k -> res/Rdout/wb_valid valid after edge k+1;
//    - RF written at edge k+2.
//  - Latency, MUL: the result leaves EX after MUL_LAT cycles, so res is valid after edge k+MUL_LAT.
//  - MUL stall: while MUL occupies EX with cycles remaining, stall=1. ID/EX holds its contents
//    and bubbles (wb_valid=0) go to WB. With MUL_LAT=1 there is no structural stall.
//  - RF read bypass: an ID-stage read of the register being written from WB in the same cycle
//    returns the WB value. Reads of RF[0] always return 0.
//  - Arithmetic:
//    - all ops are signed two's complement, truncated to WIDTH (wrap, no flags);
//    - MUL keeps the low WIDTH bits of the product;
//    - imm is sign-extended 12->WIDTH.
//  - Rd=0: the instruction flows normally and shows wb_valid=1 with its res, but RF[0] stays 0.
//  - Hazard detection compares against the EX instruction only if valid, Rd!=0 and
//    Rd==Rs1 or Rd==Rs2. Rs2 is not compared for ADDI.
//  - start=0 drains the pipeline; issue resumes with no lost state.
// CONFIGURATION
//  `FORWARD_EN defined:
//    - an EX-stage RAW match forwards the EX result into ID/EX;
//    - priority EX > WB-bypass > RF;
//    - stalls arise only from an in-progress MUL (forward once its last cycle completes).
//  `FORWARD_EN undefined:
//    - an EX-stage RAW match forces stall=1 and inserts a bubble until the producer reaches WB,
//      where the RF bypass supplies the value;
//    - cost: 1 stall cycle per dependent single-cycle pair, MUL_LAT cycles after a MUL.
//  In both builds the architectural results are identical; only timing differs.
// TESTING
//  - Reset mid-run: assert rst=0 during a MUL -> next cycle res=0, wb_valid=0, stall=0, all RF=0.
//  - ADDI r1,r0,5; ADDI r2,r0,-3 back-to-back -> WB shows (1,5) then (2,-3); RF[2]=0xFFFFFFFD.
//  - ADDI r1,r0,7; ADD r3,r1,r1 dependent ->
//    - FORWARD_EN: res 14 one cycle after r1, stall never 1;
//    - else: one stall cycle, then res 14.
//  - MUL r4,r3,r1 (14*7), MUL_LAT=2 -> stall high 1 cycle, res=98, a bubble precedes it in WB.
//  - Wrap: ADDI r5,r0,-1; MUL r6,r5,r5 -> 1; ADD of 0x7FFFFFFF+1 -> 0x80000000.
//  - SUB/AND/OR/XOR on r1=12, r2=10 -> 2, 8, 14, 6.
//  - Writes to r0 and NOPs -> RF[0] stays 0; NOP produces wb_valid=0.
//  - start=0 for 3 cycles mid-stream -> wb_valid=0 gaps, final RF contents unchanged.

Source files
------------

// File: rtl/idexwb_fwd_pipe.sv
// Decode/execute/writeback pipeline with an internal register file, multi-cycle MUL and RAW
// hazard handling. Define FORWARD_EN to forward EX results instead of stalling on RAW hazards.
module idexwb_fwd_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [AW-1:0]    Rs1,
  input  logic [AW-1:0]    Rs2,
  input  logic [AW-1:0]    Rd,
  input  logic [11:0]      imm,
  output logic             stall,
  output logic [WIDTH-1:0] res,
  output logic [AW-1:0]    Rdout,
  output logic             wb_valid
);

  typedef enum logic [2:0] {
    OpNop  = 3'b000,
    OpAdd  = 3'b001,
    OpMul  = 3'b010,
    OpAddi = 3'b011,
    OpSub  = 3'b100,
    OpAnd  = 3'b101,
    OpOr   = 3'b110,
    OpXor  = 3'b111
  } op_e;

`ifdef FORWARD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif
  localparam int unsigned CW = $clog2(MUL_LAT + 1);

  logic [WIDTH-1:0] rf_q [NREGS];

  logic             ex_valid_q;
  op_e              ex_op_q;
  logic [AW-1:0]    ex_rd_q;
  logic [WIDTH-1:0] ex_a_q, ex_b_q;
  logic [CW-1:0]    mul_cnt_q;

  logic             wb_valid_q;
  logic [AW-1:0]    wb_rd_q;
  logic [WIDTH-1:0] wb_res_q;

  op_e              op_in;
  logic             issue_req, uses_rs2, ex_writes, hit1, hit2, mul_busy, accept;
  logic [WIDTH-1:0] ex_result, imm_ext, rs1_val, rs2_val, opb;

  assign op_in     = op_e'(opcode);
  assign issue_req = start && (op_in != OpNop);
  assign uses_rs2  = (op_in != OpAddi);
  assign ex_writes = ex_valid_q && (ex_rd_q != '0);
  assign hit1      = ex_writes && (ex_rd_q == Rs1);
  assign hit2      = ex_writes && (ex_rd_q == Rs2);
  // MUL holds EX until its final cycle; in that final cycle its product is already available.
  assign mul_busy  = ex_valid_q && (ex_op_q == OpMul) && (mul_cnt_q != '0);
  assign stall     = mul_busy || (!FwdEn && issue_req && (hit1 || (uses_rs2 && hit2)));
  assign accept    = issue_req && !stall;
  assign imm_ext   = WIDTH'($signed(imm));

  always_comb begin
    ex_result = '0;
    unique case (ex_op_q)
      OpAdd, OpAddi: ex_result = ex_a_q + ex_b_q;
      OpMul:         ex_result = ex_a_q * ex_b_q;
      OpSub:         ex_result = ex_a_q - ex_b_q;
      OpAnd:         ex_result = ex_a_q & ex_b_q;
      OpOr:          ex_result = ex_a_q | ex_b_q;
      OpXor:         ex_result = ex_a_q ^ ex_b_q;
      default:       ex_result = '0;
    endcase
  end

  // Operand source priority: EX forward (if enabled) > WB bypass > register file.
  function automatic logic [WIDTH-1:0] pick(input logic [AW-1:0] a, input logic ex_hit,
                                            input logic [WIDTH-1:0] ex_val,
                                            input logic wb_hit, input logic [WIDTH-1:0] wb_val,
                                            input logic [WIDTH-1:0] rf_val);
    if (a == '0)             return '0;
    else if (FwdEn && ex_hit) return ex_val;
    else if (wb_hit)         return wb_val;
    else                     return rf_val;
  endfunction

  always_comb begin
    rs1_val = pick(Rs1, hit1, ex_result, wb_valid_q && (wb_rd_q == Rs1), wb_res_q,
                   (32'(Rs1) < NREGS) ? rf_q[Rs1] : '0);
    rs2_val = pick(Rs2, hit2, ex_result, wb_valid_q && (wb_rd_q == Rs2), wb_res_q,
                   (32'(Rs2) < NREGS) ? rf_q[Rs2] : '0);
    opb     = (op_in == OpAddi) ? imm_ext : rs2_val;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= OpNop;
      ex_rd_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      mul_cnt_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_res_q   <= '0;
      for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
    end else begin
      if (wb_valid_q && (wb_rd_q != '0) && (32'(wb_rd_q) < NREGS)) rf_q[wb_rd_q] <= wb_res_q;
      if (mul_busy) begin
        mul_cnt_q  <= mul_cnt_q - 1'b1;
        wb_valid_q <= 1'b0;
      end else begin
        wb_valid_q <= ex_valid_q;
        if (ex_valid_q) begin
          wb_rd_q  <= ex_rd_q;
          wb_res_q <= ex_result;
        end
        ex_valid_q <= accept;
        if (accept) begin
          ex_op_q   <= op_in;
          ex_rd_q   <= Rd;
          ex_a_q    <= rs1_val;
          ex_b_q    <= opb;
          mul_cnt_q <= (op_in == OpMul) ? CW'(MUL_LAT - 1) : '0;
        end
      end
    end
  end

  assign res      = wb_res_q;
  assign Rdout    = wb_rd_q;
  assign wb_valid = wb_valid_q;

endmodule

// File: tb/tb_idexwb_fwd_pipe.sv
// Self-checking bench for idexwb_fwd_pipe: architectural reference model plus a WB scoreboard
// that also predicts issue latency and stall cycles.
module tb_idexwb_fwd_pipe;
  localparam int WIDTH = 32, NREGS = 32, AW = 5, MUL_LAT = 2;
`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [2:0]       opcode = '0;
  logic [AW-1:0]    rs1 = '0, rs2 = '0, rd = '0;
  logic [11:0]      imm = '0;
  logic             stall, wb_valid;
  logic [WIDTH-1:0] res;
  logic [AW-1:0]    rdout;

  idexwb_fwd_pipe #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .Rs1(rs1), .Rs2(rs2), .Rd(rd),
    .imm(imm), .stall(stall), .res(res), .Rdout(rdout), .wb_valid(wb_valid)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0, cyc = 0, last_stalls = 0;
  bit mon_en = 1'b0;
  always @(posedge clk) cyc++;

  typedef struct { logic [AW-1:0] rd; logic [WIDTH-1:0] val; int due; bit mul; } ent_t;
  typedef struct { logic [AW-1:0] rd; logic [WIDTH-1:0] val; int cyc; } wb_t;
  ent_t q[$];
  wb_t  wb_log[$];
  logic [WIDTH-1:0] mrf [NREGS];
  logic [WIDTH-1:0] last_res = '0;

  // WB scoreboard: every cycle either the oldest pending instruction is due, or WB is empty.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (q.size() > 0 && q[0].due == cyc) begin
        if (wb_valid !== 1'b1 || res !== q[0].val || rdout !== q[0].rd)
          $display("FAIL wb cyc=%0d: got v=%b rd=%0d res=%h, want v=1 rd=%0d res=%h",
                   cyc, wb_valid, rdout, res, q[0].rd, q[0].val);
        else passes++;
        void'(q.pop_front());
      end else begin
        if (wb_valid !== 1'b0) $display("FAIL wb_idle cyc=%0d: got wb_valid=%b want 0",
                                        cyc, wb_valid);
        else passes++;
      end
      if (wb_valid === 1'b1) begin
        last_res = res;
        wb_log.push_back('{rd: rdout, val: res, cyc: cyc});
      end
    end
  end

  function automatic bit pred_stall(input logic [2:0] op, input int s1, input int s2,
                                    input bit st);
    bit r = 1'b0;
    foreach (q[i]) if (q[i].due > cyc) begin
      if (q[i].mul && cyc < q[i].due - 1) r = 1'b1;
      if (!FWD && st && op != 3'd0 && q[i].rd != 0 &&
          (q[i].rd == s1 || (op != 3'd3 && q[i].rd == s2))) r = 1'b1;
    end
    return r;
  endfunction

  task automatic model_accept(input logic [2:0] op, input int s1, input int s2, input int d,
                              input logic [11:0] im);
    logic [WIDTH-1:0] a, b, r;
    ent_t e;
    a = mrf[s1];
    b = (op == 3'd3) ? WIDTH'($signed(im)) : mrf[s2];
    case (op)
      3'd1, 3'd3: r = a + b;
      3'd2:       r = a * b;
      3'd4:       r = a - b;
      3'd5:       r = a & b;
      3'd6:       r = a | b;
      default:    r = a ^ b;
    endcase
    if (d != 0) mrf[d] = r;
    e.rd = AW'(d); e.val = r; e.mul = (op == 3'd2);
    e.due = cyc + 1 + ((op == 3'd2) ? MUL_LAT : 1);
    q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input int s1, input int s2, input int d,
                       input logic [11:0] im);
    bit exp_st;
    int n = 0;
    bit done = 1'b0;
    while (!done) begin
      @(negedge clk);
      start = 1'b1; opcode = op; rs1 = AW'(s1); rs2 = AW'(s2); rd = AW'(d); imm = im;
      #1;
      exp_st = pred_stall(op, s1, s2, 1'b1);
      checks++;
      if (stall !== exp_st) $display("FAIL stall cyc=%0d: got %b want %b", cyc, stall, exp_st);
      else passes++;
      if (stall === 1'b0) begin
        done = 1'b1;
        if (op != 3'd0) model_accept(op, s1, s2, d, im);
      end else begin
        n++;
        if (n > 20) begin
          checks++;
          $display("FAIL issue_timeout: got stall stuck for %0d cycles want <=%0d", n, MUL_LAT);
          done = 1'b1;
        end
      end
    end
    last_stalls = n;
  endtask

  task automatic idle(input int n);
    bit exp_st;
    repeat (n) begin
      @(negedge clk);
      start = 1'b0; opcode = '0;
      #1;
      if (rst) begin
        exp_st = pred_stall(3'd0, 0, 0, 1'b0);
        checks++;
        if (stall !== exp_st) $display("FAIL stall_idle cyc=%0d: got %b want %b", cyc, stall,
                                       exp_st);
        else passes++;
      end
    end
  endtask

  task automatic readout(input int r, output logic [WIDTH-1:0] v);
    issue(3'd1, r, 0, 0, 12'd0);
    idle(MUL_LAT + 2);
    v = last_res;
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] v;
    idle(3);
    checks++;
    if (res !== '0 || rdout !== '0 || wb_valid !== 1'b0 || stall !== 1'b0)
      $display("FAIL reset_state: got res=%h rd=%0d v=%b st=%b want all 0", res, rdout,
               wb_valid, stall);
    else passes++;
    @(negedge clk); rst = 1'b1;
    mon_en = 1'b1;
    issue(3'd3, 0, 0, 1, 12'd3);
    issue(3'd2, 1, 1, 2, 12'd0);
    @(negedge clk);
    mon_en = 1'b0; rst = 1'b0; start = 1'b0;
    #1;
    checks++;
    if (res !== '0 || wb_valid !== 1'b0 || stall !== 1'b0)
      $display("FAIL reset_midmul: got res=%h v=%b st=%b want 0 0 0", res, wb_valid, stall);
    else passes++;
    q.delete();
    foreach (mrf[i]) mrf[i] = '0;
    idle(2);
    @(negedge clk); rst = 1'b1;
    mon_en = 1'b1;
    for (int r = 1; r <= 2; r++) begin
      readout(r, v);
      checks++;
      if (v !== '0) $display("FAIL reset_rf r%0d: got %h want 0", r, v);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] v;
    wb_log.delete();
    issue(3'd3, 0, 0, 1, 12'd5);
    issue(3'd3, 0, 0, 2, 12'hFFD);
    idle(3);
    checks++;
    if (wb_log.size() < 2 || wb_log[0].rd !== 5'd1 || wb_log[0].val !== 32'd5 ||
        wb_log[1].rd !== 5'd2 || wb_log[1].val !== 32'hFFFFFFFD ||
        wb_log[1].cyc != wb_log[0].cyc + 1)
      $display("FAIL back_to_back: got %0d WB entries want (1,5) then (2,-3) consecutive",
               wb_log.size());
    else passes++;
    readout(2, v);
    checks++;
    if (v !== 32'hFFFFFFFD) $display("FAIL rf_r2: got %h want fffffffd", v);
    else passes++;
  endtask

  task automatic test_dependent();
    int gap;
    wb_log.delete();
    issue(3'd3, 0, 0, 1, 12'd7);
    issue(3'd1, 1, 1, 3, 12'd0);
    checks++;
    if (last_stalls != (FWD ? 0 : 1))
      $display("FAIL dep_stalls: got %0d want %0d", last_stalls, FWD ? 0 : 1);
    else passes++;
    idle(3);
    gap = (wb_log.size() >= 2) ? wb_log[1].cyc - wb_log[0].cyc : -1;
    checks++;
    if (wb_log.size() < 2 || wb_log[1].val !== 32'd14 || gap != (FWD ? 1 : 2))
      $display("FAIL dep_result: got res=%h gap=%0d want 0000000e gap=%0d",
               (wb_log.size() >= 2) ? wb_log[1].val : 'x, gap, FWD ? 1 : 2);
    else passes++;
  endtask

  task automatic test_mul();
    wb_log.delete();
    issue(3'd2, 3, 1, 4, 12'd0);
    issue(3'd3, 0, 0, 7, 12'd1);
    checks++;
    if (last_stalls != MUL_LAT - 1)
      $display("FAIL mul_stall: got %0d want %0d", last_stalls, MUL_LAT - 1);
    else passes++;
    idle(3);
    checks++;
    if (wb_log.size() < 1 || wb_log[0].rd !== 5'd4 || wb_log[0].val !== 32'd98)
      $display("FAIL mul_result: got %0d entries want (4,98)", wb_log.size());
    else passes++;
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] v;
    issue(3'd3, 0, 0, 5, 12'hFFF);
    issue(3'd2, 5, 5, 6, 12'd0);
    issue(3'd3, 0, 0, 10, 12'd1024);
    issue(3'd1, 10, 10, 10, 12'd0);
    issue(3'd2, 10, 10, 11, 12'd0);
    issue(3'd3, 0, 0, 12, 12'd512);
    issue(3'd2, 11, 12, 11, 12'd0);
    issue(3'd3, 11, 0, 13, 12'hFFF);
    issue(3'd3, 0, 0, 14, 12'd1);
    issue(3'd1, 13, 14, 15, 12'd0);
    idle(4);
    checks++;
    if (last_res !== 32'h80000000) $display("FAIL wrap_add: got %h want 80000000", last_res);
    else passes++;
    readout(6, v);
    checks++;
    if (v !== 32'd1) $display("FAIL wrap_mul: got %h want 1", v);
    else passes++;
  endtask

  task automatic test_logic_ops();
    logic [WIDTH-1:0] exp_v [4] = '{32'd2, 32'd8, 32'd14, 32'd6};
    issue(3'd3, 0, 0, 1, 12'd12);
    issue(3'd3, 0, 0, 2, 12'd10);
    idle(3);
    wb_log.delete();
    for (int k = 0; k < 4; k++) issue(3'(4 + k), 1, 2, 3 + k, 12'd0);
    idle(3);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wb_log.size() <= k || wb_log[k].val !== exp_v[k])
        $display("FAIL logic_op%0d: got %h want %h", k,
                 (wb_log.size() > k) ? wb_log[k].val : 'x, exp_v[k]);
      else passes++;
    end
  endtask

  task automatic test_r0_nop();
    logic [WIDTH-1:0] v;
    wb_log.delete();
    issue(3'd3, 0, 0, 0, 12'd9);
    issue(3'd0, 1, 2, 3, 12'd0);
    issue(3'd0, 0, 0, 0, 12'd0);
    idle(3);
    checks++;
    if (wb_log.size() != 1 || wb_log[0].val !== 32'd9)
      $display("FAIL r0_write: got %0d WB entries want 1 with res 9", wb_log.size());
    else passes++;
    readout(0, v);
    checks++;
    if (v !== '0) $display("FAIL r0_read: got %h want 0", v);
    else passes++;
  endtask

  task automatic test_drain();
    logic [WIDTH-1:0] v;
    issue(3'd3, 0, 0, 8, 12'd33);
    idle(3);
    issue(3'd3, 8, 0, 9, 12'd1);
    idle(3);
    readout(9, v);
    checks++;
    if (v !== 32'd34) $display("FAIL drain_r9: got %h want 22", v);
    else passes++;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] v;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
      issue(3'($urandom_range(0, 7)), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), 12'($urandom));
    end
    idle(4);
    for (int r = 1; r < NREGS; r++) begin
      readout(r, v);
      checks++;
      if (v !== mrf[r]) $display("FAIL rf_final r%0d: got %h want %h", r, v, mrf[r]);
      else passes++;
    end
  endtask

  initial begin
    foreach (mrf[i]) mrf[i] = '0;
    test_reset();
    test_back_to_back();
    test_dependent();
    test_mul();
    test_wrap();
    test_logic_ops();
    test_r0_nop();
    test_drain();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1);
  end

endmodule
